countdown_timer: RTL and testbench

//  Down-counting m:s:cs timer; the count-down counterpart of the stopwatch counter chain.

---
 rtl/countdown_timer.sv | 137 +++++++++++++
 tb/tb_countdown_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Down-counting m:s:cs timer with a centisecond prescaler and expiry signalling.
// Optional feature: define AUTO_RELOAD_EN to reload the preset on expiry instead of stopping.
module countdown_timer #(
    parameter int TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       load,
    input  logic [6:0] load_m,
    input  logic [6:0] load_s,
    input  logic [6:0] load_cs,
    output logic [6:0] out_m,
    output logic [6:0] out_s,
    output logic [6:0] out_cs,
    output logic       running,
    output logic       done,
    output logic       expire
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [6:0]    pre_m, pre_s, pre_cs;
    logic [6:0]    pre_m_nxt, pre_s_nxt, pre_cs_nxt;
    logic [6:0]    m_nxt, s_nxt, cs_nxt;
    logic          expire_nxt;
    logic          tick;
    logic          count_zero;
    logic          count_one;

    function automatic logic [6:0] clamp(input logic [6:0] v, input logic [6:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign tick       = (state == RUN) && (presc == PRESC_LAST);
    assign count_zero = (out_m == 7'd0) && (out_s == 7'd0) && (out_cs == 7'd0);
    assign count_one  = (out_m == 7'd0) && (out_s == 7'd0) && (out_cs == 7'd1);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        presc_nxt  = presc;
        pre_m_nxt  = pre_m;
        pre_s_nxt  = pre_s;
        pre_cs_nxt = pre_cs;
        m_nxt      = out_m;
        s_nxt      = out_s;
        cs_nxt     = out_cs;
        expire_nxt = 1'b0;

        if (load) begin
            // Load overrides everything, including a tick landing on this cycle.
            pre_m_nxt  = clamp(load_m, 7'd99);
            pre_s_nxt  = clamp(load_s, 7'd59);
            pre_cs_nxt = clamp(load_cs, 7'd99);
            m_nxt      = pre_m_nxt;
            s_nxt      = pre_s_nxt;
            cs_nxt     = pre_cs_nxt;
            presc_nxt  = '0;
            state_nxt  = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_stop && !count_zero) state_nxt = RUN;
                end
                RUN: begin
                    presc_nxt = tick ? '0 : presc + PW'(1);
                    state_nxt = start_stop ? RUN : PAUSE;
                    if (tick) begin
                        if (count_one) begin
                            expire_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                            m_nxt  = pre_m;
                            s_nxt  = pre_s;
                            cs_nxt = pre_cs;
`else
                            m_nxt     = 7'd0;
                            s_nxt     = 7'd0;
                            cs_nxt    = 7'd0;
                            state_nxt = EXPIRED;
`endif
                        end else if (out_cs != 7'd0) begin
                            cs_nxt = out_cs - 7'd1;
                        end else if (out_s != 7'd0) begin
                            cs_nxt = 7'd99;
                            s_nxt  = out_s - 7'd1;
                        end else begin
                            cs_nxt = 7'd99;
                            s_nxt  = 7'd59;
                            m_nxt  = out_m - 7'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (start_stop) state_nxt = RUN;
                end
                EXPIRED: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            presc   <= '0;
            pre_m   <= 7'd0;
            pre_s   <= 7'd0;
            pre_cs  <= 7'd0;
            out_m   <= 7'd0;
            out_s   <= 7'd0;
            out_cs  <= 7'd0;
            running <= 1'b0;
            done    <= 1'b0;
            expire  <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            pre_m   <= pre_m_nxt;
            pre_s   <= pre_s_nxt;
            pre_cs  <= pre_cs_nxt;
            out_m   <= m_nxt;
            out_s   <= s_nxt;
            out_cs  <= cs_nxt;
            running <= (state_nxt == RUN);
            done    <= (state_nxt == EXPIRED);
            expire  <= expire_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random load/run/pause traffic,
// compared every cycle against a total-centiseconds reference model.
module tb_countdown_timer;

    localparam int TICK_DIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_m = '0, load_s = '0, load_cs = '0;
    logic [6:0] out_m, out_s, out_cs;
    logic       running, done, expire;

    countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .load(load),
        .load_m(load_m), .load_s(load_s), .load_cs(load_cs),
        .out_m(out_m), .out_s(out_s), .out_cs(out_cs),
        .running(running), .done(done), .expire(expire)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the count is one integer of centiseconds.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mmode_t;
    mmode_t mode = M_IDLE;
    int total = 0, preset = 0, pre = 0;
    bit exp_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        mode = M_IDLE; total = 0; preset = 0; pre = 0; exp_m = 1'b0;
    endtask

    task automatic model_clock();
        exp_m = 1'b0;
        if (load) begin
            preset = min_i(int'(load_m), 99) * 6000 + min_i(int'(load_s), 59) * 100
                   + min_i(int'(load_cs), 99);
            total = preset;
            pre   = 0;
            mode  = M_IDLE;
        end else begin
            case (mode)
                M_IDLE:  if (start_stop && total != 0) mode = M_RUN;
                M_PAUSE: if (start_stop) mode = M_RUN;
                M_RUN: begin
                    mode = start_stop ? M_RUN : M_PAUSE;
                    if (pre == TICK_DIV - 1) begin
                        pre = 0;
                        if (total == 1) begin
                            exp_m = 1'b1;
`ifdef AUTO_RELOAD_EN
                            total = preset;
`else
                            total = 0;
                            mode  = M_EXP;
`endif
                        end else begin
                            total = total - 1;
                        end
                    end else begin
                        pre = pre + 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare();
        check("out_m", 32'(out_m), 32'(total / 6000));
        check("out_s", 32'(out_s), 32'((total % 6000) / 100));
        check("out_cs", 32'(out_cs), 32'(total % 100));
        check("running", 32'(running), 32'(mode == M_RUN));
        check("done", 32'(done), 32'(mode == M_EXP));
        check("expire", 32'(expire), 32'(exp_m));
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_load(input int m, input int s, input int cs);
        load_m = 7'(m); load_s = 7'(s); load_cs = 7'(cs);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        int n;
        int exp_cnt;

        // 1: reset values, start without a load stays idle
        model_reset();
        #12;
        compare();
        check("rst_running", 32'(running), 32'd0);
        rst = 1'b0;
        start_stop = 1'b1;
        repeat (5) step();
        check("idle_no_count", 32'(running), 32'd0);

        // 2: 0:00:03 counts down and expires once
        start_stop = 1'b0;
        do_load(0, 0, 3);
        start_stop = 1'b1;
        exp_cnt = 0;
        repeat (40) begin
            step();
            if (expire) exp_cnt++;
        end
`ifndef AUTO_RELOAD_EN
        check("t2_expire_cnt", 32'(exp_cnt), 32'd1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_cs", 32'(out_cs), 32'd0);
        start_stop = 1'b0;
        repeat (3) step();
        start_stop = 1'b1;
        repeat (3) step();
        check("t2_expired_sticky", 32'(done), 32'd1);
`endif

        // 3: borrow into minutes, pause holds, resume uses the remaining prescaler count
        start_stop = 1'b0;
        do_load(1, 0, 0);
        start_stop = 1'b1;
        n = 0;
        while (out_m != 7'd0 && n < 20) begin step(); n++; end
        check("t3_first_tick_bound", 32'(n < 20), 32'd1);
        check("t3_after_tick_s", 32'(out_s), 32'd59);
        check("t3_after_tick_cs", 32'(out_cs), 32'd99);
        repeat (4) step();
        start_stop = 1'b0;
        repeat (50) step();
        check("t3_paused_cs", 32'(out_cs), 32'd99);
        start_stop = 1'b1;
        n = 0;
        while (out_cs == 7'd99 && n < 20) begin step(); n++; end
        check("t3_resume_latency", 32'(n), 32'd6);

        // 4: clamping, and a load colliding with a tick
        start_stop = 1'b0;
        do_load(120, 75, 127);
        check("t4_clamp_m", 32'(out_m), 32'd99);
        check("t4_clamp_s", 32'(out_s), 32'd59);
        check("t4_clamp_cs", 32'(out_cs), 32'd99);
        start_stop = 1'b1;
        n = 0;
        while (!(mode == M_RUN && pre == TICK_DIV - 1) && n < 30) begin step(); n++; end
        check("t4_reach_tick_bound", 32'(n < 30), 32'd1);
        do_load(0, 0, 50);
        check("t4_load_wins_cs", 32'(out_cs), 32'd50);
        check("t4_load_wins_running", 32'(running), 32'd0);

`ifdef AUTO_RELOAD_EN
        // 5: auto reload pulses expire every 20 cycles and never sets done
        start_stop = 1'b0;
        do_load(0, 0, 2);
        start_stop = 1'b1;
        exp_cnt = 0;
        repeat (100) begin
            step();
            if (expire) exp_cnt++;
        end
        check("t5_expire_cnt", 32'(exp_cnt), 32'd4);
        check("t5_done", 32'(done), 32'd0);
`endif

        // 6: asynchronous reset mid-run clears counters and preset
        start_stop = 1'b0;
        do_load(0, 30, 40);
        start_stop = 1'b1;
        repeat (15) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare();
        check("t6_async_s", 32'(out_s), 32'd0);
        #1 rst = 1'b0;
        repeat (5) step();
        check("t6_preset_lost", 32'(running), 32'd0);

        // Random traffic: short presets so expiry is reached, occasional large ones for clamping
        repeat (4000) begin
            if ($urandom_range(0, 149) == 0) begin
                load_m  = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
                load_s  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
                load_cs = 7'($urandom_range(0, 127));
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) start_stop = ~start_stop;
            step();
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
